// File: rtl/md_ctrl.sv
// Multiply/divide controller: computes the result at accept, counts down a busy period, then commits HI/LO.
// Optional feature macro MD_DIV0_HOLD_EN: divide-by-zero leaves HI/LO untouched at commit.
module md_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_md,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [31:0]   res_hi, res_hi_nx, res_lo, res_lo_nx;
   logic [31:0]   hi_nx, lo_nx;
`ifdef MD_DIV0_HOLD_EN
   logic          hold, hold_nx;
`endif

   // Product: 64-bit operands so the low 64 bits are exact for both signednesses
   logic [63:0] prod_s, prod_u;
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Signed division through magnitudes; the zero divisor is replaced to keep the path X-free
   logic        div_signed, a_neg, b_neg, div0;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem, div_hi, div_lo;
   assign div_signed = (op == OP_DIV);
   assign a_neg      = div_signed & A[31];
   assign b_neg      = div_signed & B[31];
   assign a_mag      = a_neg ? -A : A;
   assign b_mag      = b_neg ? -B : B;
   assign div0       = (B == 32'd0);
   assign b_safe     = div0 ? 32'd1 : b_mag;
   assign q_mag      = a_mag / b_safe;
   assign r_mag      = a_mag % b_safe;
   assign quo        = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem        = a_neg ? -r_mag : r_mag;
`ifdef MD_DIV0_HOLD_EN
   assign div_lo     = quo;
   assign div_hi     = rem;
`else
   assign div_lo     = div0 ? 32'hFFFF_FFFF : quo;
   assign div_hi     = div0 ? A : rem;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         HI     <= '0;
         LO     <= '0;
`ifdef MD_DIV0_HOLD_EN
         hold   <= 1'b0;
`endif
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         res_hi <= res_hi_nx;
         res_lo <= res_lo_nx;
         HI     <= hi_nx;
         LO     <= lo_nx;
`ifdef MD_DIV0_HOLD_EN
         hold   <= hold_nx;
`endif
      end
   end

   // Accept only in IDLE; BUSY counts down and commits on the 1->0 step
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      res_hi_nx = res_hi;
      res_lo_nx = res_lo;
      hi_nx     = HI;
      lo_nx     = LO;
`ifdef MD_DIV0_HOLD_EN
      hold_nx   = hold;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     {res_hi_nx, res_lo_nx} = (op == OP_MULT) ? prod_s : prod_u;
                     cnt_nx   = CW'(MULT_CYCLES);
                     state_nx = BUSY;
`ifdef MD_DIV0_HOLD_EN
                     hold_nx  = 1'b0;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     res_hi_nx = div_hi;
                     res_lo_nx = div_lo;
                     cnt_nx    = CW'(DIV_CYCLES);
                     state_nx  = BUSY;
`ifdef MD_DIV0_HOLD_EN
                     hold_nx   = div0;
`endif
                  end
                  OP_MTHI: hi_nx = A;
                  OP_MTLO: lo_nx = A;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nx = IDLE;
`ifdef MD_DIV0_HOLD_EN
               if (!hold) begin
                  hi_nx = res_hi;
                  lo_nx = res_lo;
               end
`else
               hi_nx = res_hi;
               lo_nx = res_lo;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy     = (cnt != '0);
   assign md_stall = D_md & (start | busy);
endmodule
